// File: rtl/cpu_defs.sv
`default_nettype none
// ============================================================================
// cpu_defs : shared write-op and FSM encodings for the CPU register datapath
// Rev 1.0
// ============================================================================
package cpu_defs;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    OP_LOAD   = 2'b00,
    OP_INC    = 2'b01,
    OP_DEC    = 2'b10,
    OP_CLRALL = 2'b11
  } wr_op_e;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } bank_state_e;

endpackage
`default_nettype wire

// File: rtl/inc_dec_unit.sv
`default_nettype none
// ============================================================================
// inc_dec_unit : combinational +1/-1 with wrap carry/borrow and zero flag
// Rev 1.0
// ============================================================================
module inc_dec_unit #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] value,
  input  logic             dir,     // 0 = increment, 1 = decrement
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero
);

  always_comb begin
    if (dir) begin
      result = value - WIDTH'(1);
      carry  = (value == '0);
    end else begin
      result = value + WIDTH'(1);
      carry  = (value == '1);
    end
    zero = (result == '0);
  end

endmodule
`default_nettype wire

// File: rtl/reg_bank8.sv
`default_nettype none
// ============================================================================
// reg_bank8 : eight-entry operand register bank with load/inc/dec/clear-all
// Rev 1.0
// ============================================================================
module reg_bank8
  import cpu_defs::*;
#(
  parameter int               WIDTH   = DATA_W,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             WrValid,
  output logic             WrReady,
  input  logic [1:0]       WrOp,
  input  logic [2:0]       WrAddr,
  input  logic [WIDTH-1:0] WrData,
  output logic [WIDTH-1:0] R0,
  output logic [WIDTH-1:0] R1,
  output logic [WIDTH-1:0] R2,
  output logic [WIDTH-1:0] R3,
  output logic [WIDTH-1:0] R4,
  output logic [WIDTH-1:0] R5,
  output logic [WIDTH-1:0] R6,
  output logic [WIDTH-1:0] R7,
  output logic             Zero,
  output logic             Carry,
  output logic             ClrDone
);

  logic [WIDTH-1:0] regs_q [8];
  logic [WIDTH-1:0] regs_d [8];
  bank_state_e      state_q, state_d;
  logic [2:0]       ptr_q, ptr_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             clr_done_q, clr_done_d;

  logic             accept;
  logic [WIDTH-1:0] idu_result;
  logic             idu_carry;
  logic             idu_zero;

  inc_dec_unit #(.WIDTH(WIDTH)) u_inc_dec (
    .value  (regs_q[WrAddr]),
    .dir    (WrOp == OP_DEC),
    .result (idu_result),
    .carry  (idu_carry),
    .zero   (idu_zero)
  );

  assign WrReady = (state_q == ST_IDLE);
  assign accept  = WrValid & WrReady;

  always_comb begin
    regs_d     = regs_q;
    state_d    = state_q;
    ptr_d      = ptr_q;
    zero_d     = zero_q;
    carry_d    = carry_q;
    clr_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (wr_op_e'(WrOp))
            OP_LOAD: begin
              regs_d[WrAddr] = WrData;
              zero_d         = (WrData == '0);
              carry_d        = 1'b0;
            end
            OP_INC, OP_DEC: begin
              regs_d[WrAddr] = idu_result;
              zero_d         = idu_zero;
              carry_d        = idu_carry;
            end
            default: begin
              state_d = ST_CLEAR;
              ptr_d   = '0;
            end
          endcase
        end
      end
      ST_CLEAR: begin
        // Sweep one register per cycle; flags are left untouched by clear-all.
        regs_d[ptr_q] = RST_VAL;
        ptr_d         = ptr_q + 3'd1;
        if (ptr_q == 3'd7) begin
          state_d    = ST_IDLE;
          clr_done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < 8; i++) regs_q[i] <= RST_VAL;
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      zero_q     <= zero_d;
      carry_q    <= carry_d;
      clr_done_q <= clr_done_d;
    end
  end

  assign R0      = regs_q[0];
  assign R1      = regs_q[1];
  assign R2      = regs_q[2];
  assign R3      = regs_q[3];
  assign R4      = regs_q[4];
  assign R5      = regs_q[5];
  assign R6      = regs_q[6];
  assign R7      = regs_q[7];
  assign Zero    = zero_q;
  assign Carry   = carry_q;
  assign ClrDone = clr_done_q;

endmodule
`default_nettype wire
